// File: rtl/if_prefetch_queue_if.sv
// Fetch-stage bundle: redirect request, IM read port and the ID-facing queue head.
// master = prefetch queue, slave = surrounding pipeline (ID, IM, redirect source).
interface if_prefetch_queue_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        Stall;
  logic [31:0] im_addr;
  logic [31:0] im_instr;
  logic        valid;
  logic [31:0] PC;
  logic [31:0] PC_4;
  logic [31:0] Instr;
  logic        Err_IF_to_ID;
  logic [4:0]  ErrStat_IF_to_ID;

  modport master (
    input  redirect, redirect_pc, Stall, im_instr,
    output im_addr, valid, PC, PC_4, Instr, Err_IF_to_ID, ErrStat_IF_to_ID
  );

  modport slave (
    output redirect, redirect_pc, Stall, im_instr,
    input  im_addr, valid, PC, PC_4, Instr, Err_IF_to_ID, ErrStat_IF_to_ID
  );
endinterface

// File: rtl/if_prefetch_queue.sv
// Prefetch queue between IM and ID: one fetch per cycle, 1-cycle fetch-to-head latency, no bypass.
// ID Stall only throttles fetching through the full condition; a faulting fetch halts until redirect.
module if_prefetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter logic [31:0] IM_LIMIT = 32'h0000_4fff,
  parameter int unsigned QDEPTH   = 4,
  parameter logic [4:0]  EXC_ADEL = 5'd4,
  parameter logic [4:0]  NO_ERR   = 5'd31
) (
  input logic                 clk,
  input logic                 reset,
  if_prefetch_queue_if.master bus
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        err;
  } entry_t;

  logic [31:0]   fpc_q, fpc_d;
  logic          halt_q, halt_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  entry_t        queue_q [QDEPTH];
  entry_t        queue_d [QDEPTH];

  logic          fault;
  logic          valid_int;
  logic          pop;
  logic          push;
  entry_t        head;
  entry_t        wr_entry;

  logic [31:0]   pc_out;
  logic [31:0]   pc4_out;
  logic [31:0]   instr_out;
  logic          err_out;

  // Unsigned 32-bit range check; IM data is ignored for faulting addresses.
  assign fault = (fpc_q[1:0] != 2'b00) || (fpc_q < IM_BASE) || (fpc_q > IM_LIMIT);

  assign valid_int = (count_q != '0);
  assign pop       = valid_int && !bus.Stall;
  assign push      = !halt_q && ((count_q < FULL_CNT) || pop);
  assign head      = queue_q[rd_ptr_q];

  always_comb begin
    wr_entry.pc    = fpc_q;
    wr_entry.instr = fault ? 32'h0000_0000 : bus.im_instr;
    wr_entry.err   = fault;
  end

  always_comb begin
    fpc_d    = fpc_q;
    halt_d   = halt_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    queue_d  = queue_q;

    // Redirect flushes everything and suppresses this cycle's push and pop.
    if (bus.redirect) begin
      fpc_d    = bus.redirect_pc;
      halt_d   = 1'b0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        queue_d[wr_ptr_q] = wr_entry;
        wr_ptr_d          = wr_ptr_q + 1'b1;
        fpc_d             = fpc_q + 32'd4;
        if (fault) begin
          halt_d = 1'b1;
        end
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fpc_q    <= RESET_PC;
      halt_q   <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      fpc_q    <= fpc_d;
      halt_q   <= halt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage needs no reset: count gates visibility of every slot.
  always_ff @(posedge clk) begin
    queue_q <= queue_d;
  end

  // Empty queue still presents the fetch PC so EPC capture sees a sane address.
  always_comb begin
    pc_out    = {fpc_q[31:2], 2'b00};
    pc4_out   = fpc_q + 32'd4;
    instr_out = 32'h0000_0000;
    err_out   = 1'b0;
    if (valid_int) begin
      pc_out    = {head.pc[31:2], 2'b00};
      pc4_out   = head.pc + 32'd4;
      instr_out = head.instr;
      err_out   = head.err;
    end
  end

  assign bus.im_addr          = (fpc_q - IM_BASE) >> 2;
  assign bus.valid            = valid_int;
  assign bus.PC               = pc_out;
  assign bus.PC_4             = pc4_out;
  assign bus.Instr            = instr_out;
  assign bus.Err_IF_to_ID     = err_out;
  assign bus.ErrStat_IF_to_ID = err_out ? EXC_ADEL : NO_ERR;

endmodule

// File: doc/if_prefetch_queue.md
Name: if_prefetch_queue

Overview:
Parametrised instruction-fetch stage for the pipelined MIPS core, replacing the single IF/ID register with a QDEPTH-entry prefetch queue between the instruction memory and ID. It fetches one word per cycle while the queue has space and detects AdEL on fetch. It halts fetching after a faulting fetch, and flushes and redirects on branch, jump or exception-vector requests. ID consumes the queue head under a valid/stall handshake.

Parameters:
RESET_PC, 32'h0000_3000, fetch PC after reset
IM_BASE, 32'h0000_3000, lowest legal instruction address
IM_LIMIT, 32'h0000_4fff, highest legal instruction byte address
QDEPTH, 4, queue entries; power of 2, minimum 2
EXC_ADEL, 5'd4, ErrStat code for fetch address error
NO_ERR, 5'd31, ErrStat code for no error

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
redirect  in  1  flush queue and load redirect_pc into fetch PC
redirect_pc  in  32  new fetch address (branch, jump or handler target)
Stall  in  1  ID not accepting the head this cycle
im_addr  out  32  word index to IM, equal to (fpc - IM_BASE) >> 2
im_instr  in  32  combinational IM read data for im_addr
valid  out  1  queue non-empty; head outputs meaningful
PC  out  32  head PC with bits [1:0] forced to 0
PC_4  out  32  head PC + 4, unaligned
Instr  out  32  head instruction; 0 (nop) if the head faulted
Err_IF_to_ID  out  1  head fetch faulted
ErrStat_IF_to_ID  out  5  EXC_ADEL if Err_IF_to_ID is 1, else NO_ERR

Behaviour:
- State: fpc (32-bit fetch PC), halt flag, circular queue of {pc, instr, err}, rd_ptr and wr_ptr (log2 QDEPTH bits, wrap mod QDEPTH), count (0..QDEPTH).
- Fault: fault = (fpc[1:0] != 0) || (fpc < IM_BASE) || (fpc > IM_LIMIT). Comparisons are unsigned, 32-bit.
- pop = valid && !Stall.
- push = !halt && (count < QDEPTH || pop). A push writes {fpc, fault ? 0 : im_instr, fault} at wr_ptr, advances wr_ptr, and sets fpc <= fpc + 4, wrapping mod 2^32.
- A push with fault=1 sets halt. While halt is 1 there are no pushes and fpc holds.
- Counting: push and pop together leave count unchanged. Push only increments count; pop only decrements it.
- Full (count == QDEPTH) without a pop: no push, fpc holds.
- Empty (count == 0): valid = 0. A word pushed this cycle becomes visible at the next edge, so fetch-to-head latency is 1 cycle with no bypass. While empty: PC = {fpc[31:2], 2'b00}, PC_4 = fpc + 4, Instr = 0, Err_IF_to_ID = 0, ErrStat_IF_to_ID = NO_ERR. This gives EPC logic a sane value.
- When valid = 1, head outputs come combinationally from the entry at rd_ptr.
- Redirect priority: redirect outranks push and pop. On a redirect cycle: count <= 0, rd_ptr <= wr_ptr <= 0, halt <= 0, fpc <= redirect_pc. No entry is written or consumed. The first word at redirect_pc is pushed on the following cycle and visible two edges after redirect.
- Unaligned or out-of-range redirect_pc: accepted as-is. The next push faults and halts.
- Stall has no effect on fetching except through the full condition. Stall with an empty queue is harmless.
- Reset (outranks redirect): fpc <= RESET_PC, halt <= 0, count <= 0, pointers <= 0. Reset outputs: valid = 0, PC = RESET_PC, PC_4 = RESET_PC + 4, Instr = 0, Err_IF_to_ID = 0, ErrStat_IF_to_ID = NO_ERR. Reset mid-operation discards all queued entries.
- im_addr is combinational from fpc. IM contents for faulting addresses are ignored.

Test Plan:
- Reset, then Stall = 0, IM holding word k = 0x1000_0000 + k. First edge: valid = 0, PC = 0x3000. Next edge: PC = 0x3000, Instr = 0x1000_0000, PC_4 = 0x3004. Thereafter one entry per cycle in order.
- Stall held high for 8 cycles from reset (QDEPTH = 4): count saturates at 4 and fpc holds at 0x3010. Release Stall: heads 0x3000, 0x3004, 0x3008, 0x300c, 0x3010 appear on consecutive cycles with no gap or duplicate.
- Queue full, Stall = 0: push and pop coincide every cycle, count stays 4, and pointer wrap-around preserves order across more than 8 entries.
- redirect = 1, redirect_pc = 0x3400 with 3 entries queued: next edge valid = 0. The following edge gives PC = 0x3400 and the old entries never appear.
- redirect_pc = 0x3002: head has Err_IF_to_ID = 1, ErrStat_IF_to_ID = 4, Instr = 0, PC = 0x3000. No further pushes until the next redirect. Repeat with 0x5000 (above limit) and 0x2ffc (below base): same fault response.
- reset asserted with redirect = 1 and a full queue: next edge fpc = 0x3000 and valid = 0. Reset outranks redirect.
